machine_ctrl: RTL and testbench
===============================

Name: machine_ctrl

Overview:
- Parametrised machine sequencer that wraps the CPU + RAM pair.
- Replaces the fixed reset/clock-enable/kill timing of the top level with a controlled sequence: load a program image into RAM over a valid/ready stream, hold the CPU in reset for a programmable time, then run it.
- During RUN it gates the system clock enable and enforces a cycle watchdog.
- Sits between the test/host side and the cpu/memory instances. During LOAD it drives the RAM write port; outside LOAD the CPU owns RAM.

Parameters:
- ADDR_WIDTH, 8, RAM address width; image depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, RAM/bus data width.
- RESET_CYCLES, 4, cycles cpu_reset is held after load (>=1).
- TIMEOUT_CYCLES, 20000, RUN cycles before watchdog trip (>=1).
- CNT_WIDTH, 32, width of run cycle counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse; begins a sequence from IDLE/DONE/TIMEOUT
- load_en  in  1  sampled with start; 1 = load image first, 0 = skip to RESET_HOLD
- load_valid  in  1  image word valid
- load_ready  out  1  controller accepts image word
- load_data  in  DATA_WIDTH  image word
- load_last  in  1  final word of image
- ram_we  out  1  RAM write strobe (LOAD only)
- ram_addr  out  ADDR_WIDTH  RAM write address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_sel  out  1  1 = controller owns RAM port, 0 = CPU owns it
- cpu_reset  out  1  reset to CPU
- clk_enable  out  1  enable to system clock generator
- cpu_halt  in  1  CPU halt indication
- done  out  1  sticky; CPU halted
- timeout  out  1  sticky; watchdog tripped
- load_overflow  out  1  sticky; image filled RAM without load_last
- run_cycles  out  CNT_WIDTH  cycles spent in RUN (holds after stop)

Behaviour:
- All outputs registered. Reset (any state, mid-operation included) -> IDLE.
  - Reset values: cpu_reset=1, clk_enable=0, load_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, ram_sel=0, done=0, timeout=0, load_overflow=0, run_cycles=0.
- States: IDLE, LOAD, RESET_HOLD, RUN, DONE, TIMEOUT.
- IDLE: cpu_reset=1, clk_enable=0.
  - start & load_en -> LOAD, with write index=0, ram_sel=1, load_ready=1 next cycle.
  - start & !load_en -> RESET_HOLD.
- LOAD:
  - Handshake on load_valid & load_ready. The next cycle drives ram_we=1, ram_addr=index, ram_wdata=load_data (1-cycle write latency); index then increments.
  - load_ready deasserts the cycle after the terminating handshake.
  - Terminating handshake: load_last=1, or index=2**ADDR_WIDTH-1. The latter without load_last sets load_overflow.
  - After the final write cycle: ram_sel=0, -> RESET_HOLD.
  - load_valid=0 stalls indefinitely; no timeout applies in LOAD.
- RESET_HOLD: cpu_reset=1, clk_enable=0 for exactly RESET_CYCLES cycles, then -> RUN. On entry from IDLE/DONE/TIMEOUT, run_cycles clears to 0.
- RUN: cpu_reset=0, clk_enable=1; run_cycles += 1 per cycle.
  - cpu_halt=1 -> DONE.
  - run_cycles reaching TIMEOUT_CYCLES -> TIMEOUT.
  - halt and timeout in the same cycle: halt wins (DONE, timeout stays 0).
- DONE / TIMEOUT: clk_enable=0, cpu_reset=0 (CPU state frozen for inspection); done or timeout = 1; run_cycles held.
  - start re-enters the sequence as from IDLE and clears done, timeout, load_overflow.
- start is ignored in LOAD, RESET_HOLD and RUN.
- run_cycles saturates at all-ones; it never wraps.
- ram_we is never asserted outside LOAD; ram_sel=0 outside LOAD.

Decomposition:
- Shared package machine_pkg:
  - state enum machine_state_t;
  - default widths (ADDR_WIDTH/DATA_WIDTH = 8);
  - default RESET_CYCLES/TIMEOUT_CYCLES constants, reused by top level and benches.
- One natural sub-module: image_loader.
  - Implements the LOAD handshake, write index, write-port registers and overflow detection.
  - Exposes go/finished to the main FSM.
  - The FSM plus counters stay in machine_ctrl.

Test Plan:
- Reset: hold reset 2 cycles -> cpu_reset=1, clk_enable=0, ram_we=0, all flags 0, run_cycles=0.
- Load 3 words 0x11, 0x22, 0x33 (last on 3rd), valid continuous -> ram_we pulses with addr 0,1,2 and matching data; then cpu_reset held exactly 4 cycles; then clk_enable=1.
- ADDR_WIDTH=2, stream 4 words with load_last=0 -> writes addr 0..3, load_overflow=1, proceeds to RESET_HOLD; a 5th valid is not accepted (load_ready=0).
- load_en=0, TIMEOUT_CYCLES=10, cpu_halt=0 -> RUN for 10 cycles, timeout=1, clk_enable=0, run_cycles=10.
- cpu_halt asserted on the same cycle the watchdog would trip -> done=1, timeout=0; then start pulse -> flags clear, run_cycles=0, new sequence begins.
- Reset asserted mid-LOAD (after 2 words) -> next cycle IDLE, load_ready=0, ram_sel=0, ram_we=0; a following start + load restarts at addr 0.

Source files
------------

// File: rtl/machine_pkg.sv
// Shared types and default parameters for the machine sequencer.
package machine_pkg;

    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_RESET_CYCLES   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 20000;
    localparam int DEF_CNT_WIDTH      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RESET_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } machine_state_t;

endpackage

// File: rtl/machine_ctrl_if.sv
// Program-image stream: the host is the master, the sequencer is the slave.
interface machine_ctrl_if
    import machine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;

    modport master (output load_valid, load_data, load_last, input load_ready);
    modport slave  (input load_valid, load_data, load_last, output load_ready);

endinterface

// File: rtl/image_loader.sv
// Accepts the program image stream and turns each accepted word into one
// registered RAM write. Detects an image that fills the RAM without load_last.
module image_loader
    import machine_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,        // start a new image at index 0
    input  logic                  clear,     // new sequence: drop the overflow flag
    machine_ctrl_if.slave         lp,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_sel,
    output logic                  overflow,
    output logic                  finished   // high during the final write cycle
);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

    logic [ADDR_WIDTH-1:0] index;
    logic                  accept;
    logic                  terminate;

    assign accept    = lp.load_valid & lp.load_ready;
    assign terminate = lp.load_last | (index == LAST_INDEX);

    // Handshake, write-port registers, write index and overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            lp.load_ready <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_sel       <= 1'b0;
            overflow      <= 1'b0;
            finished      <= 1'b0;
            index         <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register here see the
            // pre-edge value of the others (e.g. finished releasing ram_sel).
            ram_we   <= 1'b0;
            finished <= 1'b0;
            if (clear) begin
                overflow <= 1'b0;
            end
            if (go) begin
                lp.load_ready <= 1'b1;
                ram_sel       <= 1'b1;
                index         <= '0;
            end else if (accept) begin
                ram_we    <= 1'b1;
                ram_addr  <= index;
                ram_wdata <= lp.load_data;
                index     <= index + 1'b1;
                if (terminate) begin
                    lp.load_ready <= 1'b0;
                    finished      <= 1'b1;
                end
                if (!lp.load_last && index == LAST_INDEX) begin
                    overflow <= 1'b1;
                end
            end else if (finished) begin
                ram_sel <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/machine_ctrl.sv
// Machine sequencer: optional image load, timed CPU reset, watched run,
// then a frozen DONE/TIMEOUT state for inspection until the next start.
module machine_ctrl
    import machine_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_en,
    machine_ctrl_if.slave         load_bus,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_sel,
    output logic                  cpu_reset,
    output logic                  clk_enable,
    input  logic                  cpu_halt,
    output logic                  done,
    output logic                  timeout,
    output logic                  load_overflow,
    output logic [CNT_WIDTH-1:0]  run_cycles
);

    localparam int                    HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  TRIP_AT   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    machine_state_t    state_q;
    machine_state_t    next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              seq_start;
    logic              load_go;
    logic              load_finished;
    logic              hold_last;
    logic              trip;
    logic              cpu_reset_d;
    logic              clk_enable_d;
    logic              done_d;
    logic              timeout_d;

    // start only counts while no sequence is in progress.
    assign seq_start = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_TIMEOUT);
    assign load_go   = seq_start & load_en;
    assign hold_last = (hold_cnt == HOLD_LAST);
    assign trip      = (run_cycles == TRIP_AT);

    image_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_loader (
        .clk       (clk),
        .reset     (reset),
        .go        (load_go),
        .clear     (seq_start),
        .lp        (load_bus),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_sel   (ram_sel),
        .overflow  (load_overflow),
        .finished  (load_finished)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic; halt is tested before the watchdog so it wins a tie.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    next_state = load_en ? ST_LOAD : ST_RESET_HOLD;
                end
            end
            ST_LOAD: begin
                if (load_finished) begin
                    next_state = ST_RESET_HOLD;
                end
            end
            ST_RESET_HOLD: begin
                if (hold_last) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    next_state = ST_DONE;
                end else if (trip) begin
                    next_state = ST_TIMEOUT;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        cpu_reset_d  = 1'b1;
        clk_enable_d = 1'b0;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        case (next_state)
            ST_RUN: begin
                cpu_reset_d  = 1'b0;
                clk_enable_d = 1'b1;
            end
            ST_DONE: begin
                cpu_reset_d = 1'b0;
                done_d      = 1'b1;
            end
            ST_TIMEOUT: begin
                cpu_reset_d = 1'b0;
                timeout_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered control outputs and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset  <= 1'b1;
            clk_enable <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            cpu_reset  <= cpu_reset_d;
            clk_enable <= clk_enable_d;
            done       <= done_d;
            timeout    <= timeout_d;
        end
    end

    // Reset-hold timer and saturating run-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            run_cycles <= '0;
        end else begin
            if (state_q == ST_RESET_HOLD && !hold_last) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
            if (seq_start) begin
                run_cycles <= '0;
            end else if (state_q == ST_RUN && run_cycles != '1) begin
                run_cycles <= run_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_machine_ctrl.sv
// Directed bench for machine_ctrl: a scoreboard queue holds the expected RAM
// writes and a monitor compares every ram_we pulse; sequencing and flags are
// checked directly by the stimulus thread.
module tb_machine_ctrl;
    import machine_pkg::*;

    localparam int AW      = 2;
    localparam int DW      = 8;
    localparam int HOLD    = DEF_RESET_CYCLES;
    localparam int TIMEOUT = 10;
    localparam int CW      = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          load_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_sel;
    logic          cpu_reset;
    logic          clk_enable;
    logic          cpu_halt;
    logic          done;
    logic          timeout;
    logic          load_overflow;
    logic [CW-1:0] run_cycles;

    int total = 0;
    int bad   = 0;

    logic [AW+DW:0] exp_q[$];   // {ram_sel, ram_addr, ram_wdata}
    logic [AW-1:0]  exp_addr;
    int             n;

    machine_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    machine_ctrl #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .RESET_CYCLES   (HOLD),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_en       (load_en),
        .load_bus      (bus),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_sel       (ram_sel),
        .cpu_reset     (cpu_reset),
        .clk_enable    (clk_enable),
        .cpu_halt      (cpu_halt),
        .done          (done),
        .timeout       (timeout),
        .load_overflow (load_overflow),
        .run_cycles    (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", ram_we, 0);
            end else begin
                check("ram_write", {ram_sel, ram_addr, ram_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic pulse_start(input logic le);
        start   = 1'b1;
        load_en = le;
        if (le) exp_addr = '0;
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic stream_word(input logic [DW-1:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        exp_q.push_back({1'b1, exp_addr, d});
        exp_addr = exp_addr + 1'b1;
        @(negedge clk);
    endtask

    // Counts reset-hold cycles up to the first RUN cycle; -1 if RUN never comes.
    task automatic measure_hold(output int cycles);
        cycles = 0;
        for (int i = 0; i < 64; i++) begin
            if (clk_enable) return;
            if (cpu_reset) cycles++;
            @(negedge clk);
        end
        cycles = -1;
    endtask

    // Ends a stream after its final handshake and checks the hand-back of RAM.
    task automatic end_load();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("ready_drop", bus.load_ready, 0);
        check("final_write_sel", ram_sel, 1);
        @(negedge clk);
        check("sel_release", ram_sel, 0);
    endtask

    // Halts the CPU in its first RUN cycle.
    task automatic halt_now();
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        check("halt_done", done, 1);
        check("halt_clk_enable", clk_enable, 0);
        check("halt_run_cycles", run_cycles, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; load_en = 1'b0; cpu_halt = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        exp_addr = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_clk_enable", clk_enable, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_sel", ram_sel, 0);
        check("rst_load_ready", bus.load_ready, 0);
        check("rst_flags", {done, timeout, load_overflow}, 0);
        check("rst_run_cycles", run_cycles, 0);
        reset = 1'b0;
        @(negedge clk);

        // Three-word image with load_last on the third word.
        pulse_start(1'b1);
        check("load_ready_up", bus.load_ready, 1);
        check("load_sel_up", ram_sel, 1);
        stream_word(8'h11, 1'b0);
        stream_word(8'h22, 1'b0);
        stream_word(8'h33, 1'b1);
        end_load();
        measure_hold(n);
        check("hold_after_load", n, HOLD);
        check("run_cpu_reset", cpu_reset, 0);
        check("run_run_cycles", run_cycles, 0);
        halt_now();
        check("load_overflow_clear", load_overflow, 0);

        // Image fills the 4-word RAM without load_last.
        pulse_start(1'b1);
        check("restart_done_clear", done, 0);
        check("restart_run_cycles", run_cycles, 0);
        for (int i = 0; i < 4; i++) stream_word(DW'(8'hA0 + i), 1'b0);
        bus.load_data = 8'hA4;
        check("fifth_not_ready", bus.load_ready, 0);
        check("overflow_set", load_overflow, 1);
        @(negedge clk);
        check("fifth_no_write", ram_we, 0);
        check("ovf_sel_release", ram_sel, 0);
        bus.load_valid = 1'b0;
        measure_hold(n);
        check("hold_after_overflow", n, HOLD);
        halt_now();
        check("overflow_sticky", load_overflow, 1);

        // Skip load, let the watchdog trip.
        pulse_start(1'b0);
        check("start_clears_overflow", load_overflow, 0);
        check("start_clears_done", done, 0);
        measure_hold(n);
        check("hold_no_load", n, HOLD);
        n = 0;
        for (int i = 0; i < 64 && clk_enable; i++) begin
            n++;
            @(negedge clk);
        end
        check("run_length", n, TIMEOUT);
        check("timeout_flag", timeout, 1);
        check("timeout_done", done, 0);
        check("timeout_clk_enable", clk_enable, 0);
        check("timeout_cpu_reset", cpu_reset, 0);
        check("timeout_run_cycles", run_cycles, TIMEOUT);
        repeat (3) @(negedge clk);
        check("timeout_run_cycles_held", run_cycles, TIMEOUT);
        check("timeout_sticky", timeout, 1);

        // Halt arrives in the same cycle the watchdog would trip.
        pulse_start(1'b0);
        check("start_clears_timeout", timeout, 0);
        check("start_clears_run_cycles", run_cycles, 0);
        measure_hold(n);
        check("hold_race", n, HOLD);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("race_pre_run_cycles", run_cycles, TIMEOUT - 1);
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        check("race_done", done, 1);
        check("race_timeout", timeout, 0);
        check("race_run_cycles", run_cycles, TIMEOUT);

        // New load, then reset after two words.
        pulse_start(1'b1);
        check("race_restart_done", done, 0);
        check("race_restart_run_cycles", run_cycles, 0);
        check("race_restart_ready", bus.load_ready, 1);
        stream_word(8'h51, 1'b0);
        stream_word(8'h52, 1'b0);
        bus.load_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ready", bus.load_ready, 0);
        check("midrst_sel", ram_sel, 0);
        check("midrst_we", ram_we, 0);
        check("midrst_cpu_reset", cpu_reset, 1);
        check("midrst_clk_enable", clk_enable, 0);
        check("midrst_writes_seen", exp_q.size(), 0);

        // Reload after reset starts again at address 0.
        pulse_start(1'b1);
        check("reload_ready", bus.load_ready, 1);
        stream_word(8'h61, 1'b1);
        end_load();
        measure_hold(n);
        check("hold_reload", n, HOLD);
        halt_now();

        check("writes_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
